// File: rtl/instr_fetch_queue.sv
// In-order instruction queue between the I-cache response port and decode.
// Holds fetched {pc, instr, adel} entries, presents the oldest to decode, and
// tracks outstanding fetches so responses never need back-pressure. A flush
// empties the queue and marks every in-flight response for discard.
module instr_fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_fire_i,
  output logic        req_allow_o,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_pc_i,
  input  logic [31:0] resp_instr_i,
  input  logic        resp_adel_i,
  input  logic        flush_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic        id_adel_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [DEPTH-1:0] adel_mem;

  logic empty;
  logic full;
  logic pop;
  logic accept;
  logic drop_old;

  // Handshake decode: everything here derives from registered state plus this cycle's inputs.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    pop      = id_ready_i & ~empty & ~flush_i;
    // A full queue can still take a response when the head leaves in the same cycle.
    accept   = resp_valid_i & (discard_q == '0) & ~flush_i & (~full | pop);
    drop_old = resp_valid_i & (discard_q != '0) & ~flush_i;
  end

  // Request gating uses only registered occupancy so a granted fetch always has a slot.
  always_comb begin
    req_allow_o = ({1'b0, count_q} + {1'b0, outst_q}) < (CW + 1)'(DEPTH);
  end

  // Head presentation: zeroed whenever the queue is empty so decode sees a clean NOP.
  always_comb begin
    id_valid_o = ~empty;
    id_pc_o    = '0;
    id_instr_o = '0;
    id_adel_o  = 1'b0;
    if (!empty) begin
      id_pc_o    = pc_mem[rd_ptr_q];
      id_instr_o = instr_mem[rd_ptr_q];
      id_adel_o  = adel_mem[rd_ptr_q];
    end
  end

  // Next-state for pointers, occupancy, outstanding and discard counters.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    outst_d   = outst_q;
    discard_d = discard_q;

    // Outstanding follows the fetch port regardless of flush; underflow clamps at zero.
    if (req_fire_i && !resp_valid_i) begin
      outst_d = outst_q + CW'(1);
    end else if (!req_fire_i && resp_valid_i && (outst_q != '0)) begin
      outst_d = outst_q - CW'(1);
    end

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      // Every pre-flush request still in flight; a same-cycle request is new-stream.
      if (resp_valid_i) begin
        discard_d = (outst_q == '0) ? '0 : outst_q - CW'(1);
      end else begin
        discard_d = outst_q;
      end
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (accept) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(accept) - CW'(pop);
      if (drop_old) begin
        discard_d = discard_q - CW'(1);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  // Entry storage: only accepted responses are written, at the write pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
      adel_mem <= '0;
    end else if (accept) begin
      pc_mem[wr_ptr_q]    <= resp_pc_i;
      instr_mem[wr_ptr_q] <= resp_instr_i;
      adel_mem[wr_ptr_q]  <= resp_adel_i;
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding means the fetch side lost track.
  a_resp_underflow: assert property (@(posedge clk) disable iff (!resetn)
    !(resp_valid_i && (outst_q == '0)));

  // A response that would be enqueued into a full queue with no pop is dropped.
  a_resp_into_full: assert property (@(posedge clk) disable iff (!resetn)
    !(resp_valid_i && full && !pop && (discard_q == '0) && !flush_i));

  // A request granted while the counter is already at its ceiling.
  a_outst_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(req_fire_i && !resp_valid_i && (outst_q == CW'(DEPTH))));

  // Discarded responses are a subset of outstanding ones.
  a_discard_bound: assert property (@(posedge clk) disable iff (!resetn)
    discard_q <= outst_q);
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios pinned with literal
// expectations, then randomized traffic compared every cycle against a queue model.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        resetn;
  logic        req_fire;
  logic        req_allow;
  logic        resp_valid;
  logic [31:0] resp_pc;
  logic [31:0] resp_instr;
  logic        resp_adel;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_adel;

  instr_fetch_queue #(
    .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_fire_i   (req_fire),
    .req_allow_o  (req_allow),
    .resp_valid_i (resp_valid),
    .resp_pc_i    (resp_pc),
    .resp_instr_i (resp_instr),
    .resp_adel_i  (resp_adel),
    .flush_i      (flush),
    .id_ready_i   (id_ready),
    .id_valid_o   (id_valid),
    .id_pc_o      (id_pc),
    .id_instr_o   (id_instr),
    .id_adel_o    (id_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ent_t;

  // Reference model: FIFO of entries plus in-flight and to-be-dropped response counts.
  ent_t m_q[$];
  int   m_out;
  int   m_disc;

  int n_chk;
  int n_err;
  bit cmp_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_q.delete();
    m_out  = 0;
    m_disc = 0;
  endfunction

  // Apply this cycle's inputs to the model, using the pre-edge state throughout.
  function automatic void model_step();
    ent_t e;
    bit   do_pop;
    e.pc    = resp_pc;
    e.instr = resp_instr;
    e.adel  = resp_adel;
    do_pop  = id_ready && (m_q.size() != 0) && !flush;
    if (flush) begin
      m_q.delete();
      m_disc = m_out - int'(resp_valid);
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (resp_valid) begin
        if (m_disc > 0) m_disc--;
        else m_q.push_back(e);
      end
    end
    m_out = m_out + int'(req_fire) - int'(resp_valid);
  endfunction

  function automatic bit m_allow();
    return (m_q.size() + m_out) < DEPTH;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (resetn) model_step();
    #1;
  endtask

  task automatic set(input bit req, input bit rv, input logic [31:0] pc,
                     input logic [31:0] ins, input bit adel, input bit fl, input bit rdy);
    req_fire   = req;
    resp_valid = rv;
    resp_pc    = pc;
    resp_instr = ins;
    resp_adel  = adel;
    flush      = fl;
    id_ready   = rdy;
  endtask

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("valid", {31'b0, id_valid}, {31'b0, m_q.size() != 0});
        chk("pc", id_pc, (m_q.size() != 0) ? m_q[0].pc : 32'h0);
        chk("instr", id_instr, (m_q.size() != 0) ? m_q[0].instr : 32'h0);
        chk("adel", {31'b0, id_adel}, {31'b0, (m_q.size() != 0) ? m_q[0].adel : 1'b0});
        chk("allow", {31'b0, req_allow}, {31'b0, m_allow()});
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_err  = 0;
    cmp_en = 1'b0;
    resetn = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    tick();
    tick();
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_allow", {31'b0, req_allow}, 32'h1);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    resetn = 1'b1;
    cmp_en = 1'b1;

    // 1: three in-order responses, each visible one cycle later.
    set(1, 0, 0, 0, 0, 0, 1);
    repeat (3) tick();
    set(0, 1, 32'hBFC00000, 32'h11111111, 0, 0, 1); tick();
    chk("t1_pc0", id_pc, 32'hBFC00000);
    chk("t1_ins0", id_instr, 32'h11111111);
    set(0, 1, 32'hBFC00004, 32'h22222222, 0, 0, 1); tick();
    chk("t1_pc1", id_pc, 32'hBFC00004);
    set(0, 1, 32'hBFC00008, 32'h33333333, 0, 0, 1); tick();
    chk("t1_pc2", id_pc, 32'hBFC00008);
    set(0, 0, 0, 0, 0, 0, 1); tick();
    chk("t1_empty", {31'b0, id_valid}, 32'h0);
    chk("t1_allow", {31'b0, req_allow}, 32'h1);

    // 2: stall decode and fill; a pop coinciding with a push keeps occupancy.
    set(1, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    chk("t2_allow_out4", {31'b0, req_allow}, 32'h0);
    set(0, 1, 32'h100, 32'hA0, 0, 0, 0); tick();
    set(0, 1, 32'h104, 32'hA1, 0, 0, 0); tick();
    set(0, 1, 32'h108, 32'hA2, 0, 0, 0); tick();
    chk("t2_head", id_pc, 32'h100);
    set(0, 1, 32'h10C, 32'hA3, 0, 0, 1); tick();
    chk("t2_adv", id_pc, 32'h104);
    chk("t2_allow3", {31'b0, req_allow}, 32'h1);
    set(1, 0, 0, 0, 0, 0, 0); tick();
    set(0, 1, 32'h110, 32'hA4, 0, 0, 0); tick();
    chk("t2_full_allow", {31'b0, req_allow}, 32'h0);
    chk("t2_full_head", id_pc, 32'h104);

    // 3: flush with two queued and two in flight; old responses dropped.
    set(0, 0, 0, 0, 0, 0, 1); repeat (2) tick();
    chk("t3_head", id_pc, 32'h10C);
    set(1, 0, 0, 0, 0, 0, 0); repeat (2) tick();
    set(0, 0, 0, 0, 0, 1, 0); tick();
    chk("t3_flush", {31'b0, id_valid}, 32'h0);
    set(1, 1, 32'hDEAD0000, 32'hDEAD, 0, 0, 0); tick();
    chk("t3_drop1", {31'b0, id_valid}, 32'h0);
    set(0, 1, 32'hDEAD0004, 32'hDEAD, 0, 0, 0); tick();
    chk("t3_drop2", {31'b0, id_valid}, 32'h0);
    set(0, 1, 32'hBFC00380, 32'h12345678, 0, 0, 0); tick();
    chk("t3_new_pc", id_pc, 32'hBFC00380);
    chk("t3_new_ins", id_instr, 32'h12345678);

    // 4: flush coinciding with a response and a new request.
    set(1, 0, 0, 0, 0, 0, 1); tick();
    set(1, 0, 0, 0, 0, 0, 1); tick();
    set(1, 1, 32'hDEAD0008, 32'hDEAD, 0, 1, 1); tick();
    chk("t4_flush", {31'b0, id_valid}, 32'h0);
    set(0, 1, 32'hDEAD000C, 32'hDEAD, 0, 0, 0); tick();
    chk("t4_drop", {31'b0, id_valid}, 32'h0);
    set(0, 1, 32'h200, 32'hB0, 0, 0, 0); tick();
    chk("t4_new_pc", id_pc, 32'h200);

    // 5: address-error flag travels with its entry only.
    set(1, 0, 0, 0, 0, 0, 1); tick();
    set(1, 0, 0, 0, 0, 0, 0); tick();
    set(0, 1, 32'h1, 32'hC0, 1, 0, 0); tick();
    chk("t5_pc", id_pc, 32'h1);
    chk("t5_adel", {31'b0, id_adel}, 32'h1);
    set(0, 1, 32'h8, 32'hC1, 0, 0, 1); tick();
    chk("t5_pc2", id_pc, 32'h8);
    chk("t5_adel2", {31'b0, id_adel}, 32'h0);

    // 6: asynchronous reset in the middle of a fill.
    set(1, 0, 0, 0, 0, 0, 0); repeat (2) tick();
    set(0, 1, 32'h300, 32'hD0, 0, 0, 0); tick();
    #2;
    resetn = 1'b0;
    model_clear();
    #1;
    chk("t6_valid", {31'b0, id_valid}, 32'h0);
    chk("t6_pc", id_pc, 32'h0);
    chk("t6_instr", id_instr, 32'h0);
    chk("t6_adel", {31'b0, id_adel}, 32'h0);
    chk("t6_allow", {31'b0, req_allow}, 32'h1);
    set(0, 0, 0, 0, 0, 0, 0);
    tick();
    resetn = 1'b1;
    chk("t6_post_allow", {31'b0, req_allow}, 32'h1);

    // Randomized legal traffic.
    for (int c = 0; c < 3000; c++) begin
      set(m_allow() && ($urandom_range(0, 2) != 0),
          (m_out > 0) && ($urandom_range(0, 4) < 3),
          $urandom, $urandom, ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 3) != 0));
      tick();
    end

    set(0, 0, 0, 0, 0, 0, 0);
    tick();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
